// File: rtl/fu_reflect_pipe.sv
// -----------------------------------------------------------------------------
// fu_reflect_pipe -- pipelined bit/byte reflection function unit
//
// Purpose
//   Triggered by t1load, computes one of several bit/byte reordering functions
//   of t1data and delivers the result on r1data exactly `latency` unlocked
//   rising edges later. One trigger can be accepted per cycle. Results emerge
//   in issue order with no bubbles.
//
// Opcodes (t1opcode)
//   0 REFLECT   full-width bit reversal
//   1 REFLECT8  reverse low 8 bits, upper bits zero
//   2 REFLECT16 reverse low 16 bits, upper bits zero
//   3 REFLECTB  reverse bits inside each byte lane
//   4 BSWAP     reverse byte-lane order
//   5 REFLECTN  reverse low n bits, n = o1 register clamped to busw
//   6,7         reserved, result 0
//
// Ports
//   clk       in   1     rising-edge clock
//   rstx      in   1     asynchronous active-low reset
//   glock     in   1     global lock, freezes every register
//   t1data    in   busw  trigger operand
//   t1load    in   1     trigger strobe
//   t1opcode  in   3     operation select
//   o1data    in   busw  operand 2 (bit count for REFLECTN)
//   o1load    in   1     operand 2 load strobe
//   r1data    out  busw  result register (holds last result)
//
// Configuration
//   FU_REFLECT_PIPE_VARW_EN  when defined, builds the o1 register and the
//                            REFLECTN datapath. When undefined, o1data/o1load
//                            are ignored and opcode 5 returns 0.
// -----------------------------------------------------------------------------

// Single byte-lane bit reversal, instantiated once per lane.
module fu_reflect_lane (
    input  logic [7:0] din,
    output logic [7:0] rev
);
    always_comb begin
        rev = '0;
        for (int j = 0; j < 8; j++) rev[j] = din[7-j];
    end
endmodule

module fu_reflect_pipe #(
    parameter int busw    = 32,
    parameter int latency = 2
) (
    input  logic            clk,
    input  logic            rstx,
    input  logic            glock,
    input  logic [busw-1:0] t1data,
    input  logic            t1load,
    input  logic [2:0]      t1opcode,
    input  logic [busw-1:0] o1data,
    input  logic            o1load,
    output logic [busw-1:0] r1data
);
    localparam int LANES = busw / 8;

    localparam logic [2:0] OP_REFLECT   = 3'd0;
    localparam logic [2:0] OP_REFLECT8  = 3'd1;
    localparam logic [2:0] OP_REFLECT16 = 3'd2;
    localparam logic [2:0] OP_REFLECTB  = 3'd3;
    localparam logic [2:0] OP_BSWAP     = 3'd4;
    localparam logic [2:0] OP_REFLECTN  = 3'd5;

    logic            trig;
    logic [busw-1:0] rev_all;
    logic [busw-1:0] rev_lanes;
    logic [busw-1:0] bswap;
    logic [busw-1:0] rev_n;
    logic [busw-1:0] res;
    logic            unused;

    assign trig = t1load & ~glock;

    // ---------------------------------------------------------------- datapath
    always_comb begin
        rev_all = '0;
        for (int i = 0; i < busw; i++) rev_all[i] = t1data[busw-1-i];
    end

    always_comb begin
        bswap = '0;
        for (int b = 0; b < LANES; b++) bswap[8*b +: 8] = t1data[8*(LANES-1-b) +: 8];
    end

    logic [LANES-1:0][7:0] lane_in;
    logic [LANES-1:0][7:0] lane_out;
    assign lane_in   = t1data;
    assign rev_lanes = lane_out;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            fu_reflect_lane u_lane (
                .din (lane_in[g]),
                .rev (lane_out[g])
            );
        end
    endgenerate

`ifdef FU_REFLECT_PIPE_VARW_EN
    // Bit count needs to represent 0..busw inclusive.
    localparam int              NW    = $clog2(busw + 1);
    localparam logic [busw-1:0] W_VAL = busw'(busw);

    logic [busw-1:0] o1_q;
    logic [busw-1:0] o1_cur;
    logic [NW-1:0]   n_eff;

    // A load in the trigger cycle is forwarded straight to the operation.
    assign o1_cur = o1load ? o1data : o1_q;
    assign n_eff  = (o1_cur >= W_VAL) ? NW'(busw) : o1_cur[NW-1:0];

    // Reversing the low n bits equals the full reversal shifted down by
    // busw-n; a shift of busw (n=0) yields zero.
    assign rev_n = rev_all >> (NW'(busw) - n_eff);

    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx)
            o1_q <= '0;
        else if (o1load && !glock)
            o1_q <= o1data;
    end
`else
    assign rev_n = '0;
`endif

    always_comb begin
        res = '0;
        case (t1opcode)
            OP_REFLECT:   res = rev_all;
            OP_REFLECT8:  res = rev_all >> (busw - 8);
            OP_REFLECT16: res = rev_all >> (busw - 16);
            OP_REFLECTB:  res = rev_lanes;
            OP_BSWAP:     res = bswap;
            OP_REFLECTN:  res = rev_n;
            default:      res = '0;
        endcase
    end

    // ---------------------------------------------------------------- pipeline
    // Stage k register input is element k of the *_pipe vectors; element 0 is
    // the freshly computed result. The last stage doubles as r1data and only
    // loads on a valid result so it holds between operations.
    logic [latency-1:0]            vld_q;
    logic [latency-1:0][busw-1:0]  dat_q;
    logic [latency:0]              vld_pipe;
    logic [latency:0][busw-1:0]    dat_pipe;

    assign vld_pipe = {vld_q, trig};
    assign dat_pipe = {dat_q, res};

    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            vld_q <= '0;
            dat_q <= '0;
        end else if (!glock) begin
            for (int k = 0; k < latency; k++) begin
                vld_q[k] <= vld_pipe[k];
                if (vld_pipe[k]) dat_q[k] <= dat_pipe[k];
            end
        end
    end

    assign r1data = dat_q[latency-1];

    // Final valid has no consumer beyond the held result register.
`ifdef FU_REFLECT_PIPE_VARW_EN
    assign unused = vld_pipe[latency];
`else
    assign unused = ^{o1data, o1load, vld_pipe[latency]};
`endif

endmodule
